trap_dump_ctrl: RTL
===================

// Module: trap_dump_ctrl
// PURPOSE
//  Synthesisable end-of-program controller for the pipelined core. Watches the decode-stage
//  instruction for the halt trap, or a cycle-count watchdog. Freezes the pipeline, waits for it
//  to drain, then reads a parametrised data-memory window. The window is streamed one word at a
//  time over a valid/ready port, for a bench or debug UART to consume.
// PARAMETERS
//  DATA_W        32            memory word width (multiple of 8)
//  ADDR_W        32            byte-address width
//  TRAP_WORD     32'h44000300  instruction encoding that ends the program
//  DUMP_BASE     32'h2000      first byte address dumped (word aligned)
//  DUMP_WORDS    64            words dumped (>=1)
//  DRAIN_CYCLES  4             cycles between halt assertion and first read (>=1)
//  TIMEOUT       5000          watchdog limit in cycles; 0 disables the watchdog
//  CNT_W         16            width of cycle_count
// PORTS
//  clk           in   1        core clock
//  rst           in   1        asynchronous, active-low reset
//  instr         in   32       decode-stage instruction
//  instr_valid   in   1        instr is a real (non-bubble) instruction this cycle
//  halt          out  1        freeze PC/pipeline writes
//  mem_rd_en     out  1        data-memory read strobe
//  mem_rd_addr   out  ADDR_W   data-memory byte address
//  mem_rd_data   in   DATA_W   read data, valid the cycle after mem_rd_en
//  dump_valid    out  1        dump word available
//  dump_ready    in   1        consumer accepts the word
//  dump_addr     out  ADDR_W   byte address of dump_data
//  dump_data     out  DATA_W   dumped word
//  dump_last     out  1        current word is the final word of the window
//  done          out  1        dump complete (sticky until reset)
//  timeout_flag  out  1        halt was caused by the watchdog (sticky)
//  cycle_count   out  CNT_W    cycles spent in RUN; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All outputs are 0; state=RUN.
//   - Internal address register = DUMP_BASE; drain counter = 0.
//  States: RUN -> DRAIN -> READ -> HOLD -> (READ | DONE)
//  RUN
//   - cycle_count increments each cycle.
//   - instr_valid && instr==TRAP_WORD -> DRAIN, halt=1 from the next cycle.
//   - Else if TIMEOUT!=0 && cycle_count==TIMEOUT-1 -> DRAIN, timeout_flag=1.
//   - If trap and timeout occur in the same cycle, trap wins and timeout_flag stays 0.
//   - A trap with instr_valid=0 is ignored.
//  DRAIN
//   - halt=1. Stay for exactly DRAIN_CYCLES cycles, then go to READ.
//   - cycle_count is frozen. Further traps are ignored.
//  READ
//   - One cycle: mem_rd_en=1, mem_rd_addr=address register. Then go to HOLD.
//   - mem_rd_en is 0 in every other state; mem_rd_addr holds its last value.
//  HOLD (first cycle)
//   - Capture mem_rd_data into dump_data and the address into dump_addr.
//   - dump_valid=1; dump_last=1 iff this is word DUMP_WORDS-1.
//  HOLD (handshake)
//   - dump_valid/data/addr/last stay stable until dump_valid&&dump_ready.
//   - On handshake with dump_last=0: address += DATA_W/8 (mod 2^ADDR_W), go to READ.
//   - On handshake with dump_last=1: go to DONE.
//   - dump_valid drops the cycle after the handshake.
//   - Peak throughput: 1 word per 2 cycles.
//  DONE
//   - done=1, halt=1, dump_valid=0. Terminal until reset.
//  General
//   - halt=1 in all states except RUN.
//   - dump_ready is ignored when dump_valid=0.
//   - A reset mid-dump aborts immediately. The next run restarts at DUMP_BASE.
// TESTING
//  1. Trap at cycle 10
//     - halt=1 at cycle 11. First mem_rd_en at cycle 11+DRAIN_CYCLES, addr 0x2000.
//     - 64 words streamed; done=1; timeout_flag=0.
//  2. No trap, TIMEOUT=20
//     - DRAIN is entered when cycle_count==19. timeout_flag=1.
//     - Dump is identical to scenario 1.
//  3. dump_ready low for 5 cycles on word 3 (addr 0x200C)
//     - dump_data/dump_addr are held stable.
//     - Exactly one transfer occurs; no address is skipped.
//  4. Trap and timeout in the same cycle -> timeout_flag=0.
//     Trap word with instr_valid=0 -> halt stays 0.
//  5. Reset asserted while in HOLD at word 10
//     - All outputs 0 immediately.
//     - Re-trap dumps from 0x2000 again.
//  6. DUMP_WORDS=1, DATA_W=64
//     - A single word with dump_last=1; done=1 after the handshake.
//     - Second instance DUMP_BASE=0xFFFFFFF8, DUMP_WORDS=2: the address wraps to 0x0.

Source files
------------

// File: rtl/trap_dump_ctrl_if.sv
// rtl/trap_dump_ctrl_if.sv - decode, data-memory read and dump stream signals of trap_dump_ctrl
interface trap_dump_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [31:0]       instr;
   logic              instr_valid;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;

   // controller side: watches decode, reads memory, sources the dump stream
   modport master (
      input  instr, instr_valid, mem_rd_data, dump_ready,
      output mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data, dump_last
   );

   // environment side: core decode stage, data memory and dump consumer
   modport slave (
      output instr, instr_valid, mem_rd_data, dump_ready,
      input  mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data, dump_last
   );
endinterface

// File: rtl/trap_dump_ctrl.sv
// rtl/trap_dump_ctrl.sv - halt-trap / watchdog end-of-program controller with memory window dump
module trap_dump_ctrl #(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 32,
   parameter logic [31:0]       TRAP_WORD    = 32'h44000300,
   parameter logic [ADDR_W-1:0] DUMP_BASE    = 'h2000,
   parameter int                DUMP_WORDS   = 64,
   parameter int                DRAIN_CYCLES = 4,
   parameter int                TIMEOUT      = 5000,
   parameter int                CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   trap_dump_ctrl_if.master bus,
   output logic             halt,
   output logic             done,
   output logic             timeout_flag,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int                IDX_W     = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
   localparam int                DRN_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DUMP_WORDS - 1);
   localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   // TIMEOUT is expected to fit in CNT_W; the compare uses its truncated value
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_DRAIN,
      S_READ,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cycle_cnt_q;
   logic              timeout_q;
   logic [DRN_W-1:0]  drain_q;
   logic [IDX_W-1:0]  idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] data_q;
   logic              first_q;

   logic              trap_hit;
   logic              to_hit;
   logic              last_c;
   logic              rd_en_c;
   logic              valid_c;
   logic              xfer;

   // a bubble carrying the trap encoding must not end the program
   assign trap_hit = bus.instr_valid && (bus.instr == TRAP_WORD);
   assign to_hit   = (TIMEOUT != 0) && (cycle_cnt_q == TO_LAST);
   assign last_c   = (state_q == S_HOLD) && (idx_q == LAST_IDX);
   assign xfer     = (state_q == S_HOLD) && bus.dump_ready;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_RUN;
      else      state_q <= state_d;
   end

   // next-state and control outputs
   always_comb begin
      state_d = state_q;
      halt    = 1'b1;
      rd_en_c = 1'b0;
      valid_c = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_RUN: begin
            halt = 1'b0;
            if (trap_hit || to_hit) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_q == DRN_LAST) state_d = S_READ;
         end
         S_READ: begin
            rd_en_c = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            valid_c = 1'b1;
            if (bus.dump_ready) state_d = last_c ? S_DONE : S_READ;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            halt    = 1'b0;
            state_d = S_RUN;
         end
      endcase
   end

   // run-time cycle counter (saturating) and watchdog cause flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
         if (cycle_cnt_q != CNT_MAX) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (!trap_hit && to_hit)    timeout_q   <= 1'b1;
      end
   end

   // drain counter: wraps back to zero on the final drain cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_q <= '0;
      end else if (state_q == S_DRAIN) begin
         drain_q <= (drain_q == DRN_LAST) ? '0 : drain_q + DRN_W'(1);
      end
   end

   // window walker: address and word index advance only on an accepted non-final word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= DUMP_BASE;
         idx_q  <= '0;
      end else if (xfer && !last_c) begin
         addr_q <= addr_q + ADDR_STEP;
         idx_q  <= idx_q + IDX_W'(1);
      end
   end

   // read address latch (doubles as dump address) and first-HOLD-cycle marker
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr_q <= '0;
         first_q   <= 1'b0;
      end else begin
         first_q <= (state_q == S_READ);
         if (state_q == S_READ) rd_addr_q <= addr_q;
      end
   end

   // capture read data on the first HOLD cycle so it stays stable while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else if ((state_q == S_HOLD) && first_q) begin
         data_q <= bus.mem_rd_data;
      end
   end

   // memory data is forwarded on the first HOLD cycle so a word can leave every 2 cycles
   assign bus.dump_data   = ((state_q == S_HOLD) && first_q) ? bus.mem_rd_data : data_q;
   assign bus.dump_addr   = rd_addr_q;
   assign bus.dump_valid  = valid_c;
   assign bus.dump_last   = last_c;
   assign bus.mem_rd_en   = rd_en_c;
   assign bus.mem_rd_addr = (state_q == S_READ) ? addr_q : rd_addr_q;
   assign timeout_flag    = timeout_q;
   assign cycle_count     = cycle_cnt_q;

endmodule
